fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer between the PC/redirect logic and the byte-addressed instruction memory.

---
 rtl/fetch_ctrl.sv | 175 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the fetch PC, keeps at most one word-aligned read outstanding to the
// instruction memory, and buffers returned words with their PCs in a small
// FIFO that feeds decode over a valid/ready handshake. A redirect flushes the
// FIFO, retargets the PC and turns any in-flight read into a discarded one.

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    // FETCH: may request; WAIT: own response pending; KILL: stale response pending
    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_WAIT  = 2'b01,
        ST_KILL  = 2'b10
    } state_t;

    state_t             state;
    state_t             state_base;
    state_t             state_nxt;
    logic [31:0]        fetch_pc;
    logic [31:0]        issue_pc;
    logic [31:0]        redirect_aligned;
    logic [31:0]        buf_inst [BUF_DEPTH];
    logic [31:0]        buf_pc   [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic               issue;
    logic               push;
    logic               pop;
    logic               outstanding;
    logic               req_nxt;

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign mem_addr         = fetch_pc;
    assign inst             = buf_inst[rd_ptr];
    assign inst_pc          = buf_pc[rd_ptr];

    // Next-state, FIFO occupancy and next request decision
    always_comb begin
        issue       = mem_req & mem_gnt;
        outstanding = (state == ST_WAIT) || (state == ST_KILL);
        push        = (state == ST_WAIT) & mem_rvalid & ~redirect_valid;
        pop         = inst_valid & inst_ready & ~redirect_valid;

        state_base = ST_FETCH;
        case (state)
            ST_FETCH: begin
                if (issue) begin
                    state_base = ST_WAIT;
                end else begin
                    state_base = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_base = ST_FETCH;
                end else begin
                    state_base = ST_WAIT;
                end
            end
            ST_KILL: begin
                if (mem_rvalid) begin
                    state_base = ST_FETCH;
                end else begin
                    state_base = ST_KILL;
                end
            end
            default: begin
                state_base = ST_FETCH;
            end
        endcase

        // A redirect leaves a read in flight only if one was just issued or
        // is still waiting for its data; that read must then be discarded.
        if (redirect_valid) begin
            if (((state == ST_FETCH) && issue) || (outstanding && !mem_rvalid)) begin
                state_nxt = ST_KILL;
            end else begin
                state_nxt = ST_FETCH;
            end
        end else begin
            state_nxt = state_base;
        end

        if (redirect_valid) begin
            count_nxt = {CNT_W{1'b0}};
        end else begin
            count_nxt = count + CNT_W'(push) - CNT_W'(pop);
        end

        req_nxt = (state_nxt == ST_FETCH) && (count_nxt < DEPTH_C);
    end

    // Sequencer: state, fetch/issue PCs and the registered memory request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FETCH;
            fetch_pc <= RESET_PC;
            issue_pc <= RESET_PC;
            mem_req  <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_req <= req_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end else begin
                fetch_pc <= fetch_pc;
            end
            if (issue) begin
                issue_pc <= fetch_pc;
            end else begin
                issue_pc <= issue_pc;
            end
        end
    end

    // Instruction FIFO: storage, pointers, occupancy and head-valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= {PTR_W{1'b0}};
            rd_ptr     <= {PTR_W{1'b0}};
            count      <= {CNT_W{1'b0}};
            inst_valid <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_inst[i] <= 32'h0000_0000;
                buf_pc[i]   <= 32'h0000_0000;
            end
        end else if (redirect_valid) begin
            wr_ptr     <= {PTR_W{1'b0}};
            rd_ptr     <= {PTR_W{1'b0}};
            count      <= {CNT_W{1'b0}};
            inst_valid <= 1'b0;
        end else begin
            if (push) begin
                buf_inst[wr_ptr] <= mem_rdata;
                buf_pc[wr_ptr]   <= issue_pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end else begin
                wr_ptr <= wr_ptr;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end else begin
                rd_ptr <= rd_ptr;
            end
            count      <= count_nxt;
            inst_valid <= (count_nxt != {CNT_W{1'b0}});
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized self-checking bench for fetch_ctrl.
// A behavioural memory answers every issued read with a PC-derived word after
// a random latency. The reference model only tracks architectural intent: the
// next address that should be issued and the next PC decode should receive.
// Both start at the reset PC or the latest redirect target and step by 4.

module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    int checks   = 0;
    int failures = 0;

    // reference model
    logic [31:0] model_fpc;
    logic [31:0] exp_pc;
    bit          out_busy;
    int          out_delay;
    logic [31:0] out_addr;

    // previous-cycle observations
    bit          prev_redir, prev_req, prev_gnt, prev_valid, prev_ready;
    logic [31:0] prev_addr, prev_inst, prev_inst_pc;

    // stimulus knobs and counters
    int          gnt_pct, ready_pct, redir_pct, lat_max;
    bit          force_redir;
    logic [31:0] force_tgt;
    bit          coincide_mode, coincide_hit;
    int          pops, issues, valid_cnt;
    logic [31:0] last_issue_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0:       t = 32'($urandom_range(0, 4095));
            1:       t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: t = $urandom();
        endcase
        return t;
    endfunction

    task automatic clear_model();
        model_fpc   = 32'h0000_0000;
        exp_pc      = 32'h0000_0000;
        out_busy    = 1'b0;
        out_delay   = 0;
        prev_redir  = 1'b0;
        prev_req    = 1'b0;
        prev_gnt    = 1'b0;
        prev_valid  = 1'b0;
        prev_ready  = 1'b0;
        force_redir = 1'b0;
    endtask

    // One clock cycle: at the falling edge observe, check and drive inputs.
    task automatic step();
        bit          busy_before, redir, iss, pp;
        logic [31:0] tgt;
        @(negedge clk);
        busy_before = out_busy;
        mem_rvalid  = 1'b0;
        mem_rdata   = $urandom();
        if (out_busy) begin
            if (out_delay == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(out_addr);
                out_busy   = 1'b0;
            end else begin
                out_delay--;
            end
        end
        mem_gnt    = ($urandom_range(0, 99) < gnt_pct);
        inst_ready = ($urandom_range(0, 99) < ready_pct);
        redir      = ($urandom_range(0, 99) < redir_pct);
        tgt        = rand_target();
        if (force_redir) begin
            redir       = 1'b1;
            tgt         = force_tgt;
            force_redir = 1'b0;
        end
        if (coincide_mode && mem_rvalid && inst_valid) begin
            inst_ready    = 1'b1;
            redir         = 1'b1;
            tgt           = force_tgt;
            coincide_hit  = 1'b1;
            coincide_mode = 1'b0;
        end
        redirect_valid = redir;
        redirect_pc    = redir ? tgt : $urandom();

        if (prev_redir)
            check("flush_after_redirect", 32'(inst_valid), 32'd0);
        if (prev_req && !prev_gnt && !prev_redir) begin
            check("req_hold", 32'(mem_req), 32'd1);
            check("addr_hold", mem_addr, prev_addr);
        end
        if (prev_valid && !prev_ready && !prev_redir) begin
            check("head_valid_hold", 32'(inst_valid), 32'd1);
            check("head_inst_hold", inst, prev_inst);
            check("head_pc_hold", inst_pc, prev_inst_pc);
        end

        iss = mem_req && mem_gnt;
        if (iss) begin
            check("one_outstanding", 32'(busy_before), 32'd0);
            check("issue_addr", mem_addr, model_fpc);
            model_fpc       = model_fpc + 32'd4;
            last_issue_addr = mem_addr;
            issues++;
            out_busy  = 1'b1;
            out_addr  = mem_addr;
            out_delay = $urandom_range(1, lat_max) - 1;
        end

        pp = inst_valid && inst_ready && !redir;
        if (pp) begin
            check("inst_pc", inst_pc, exp_pc);
            check("inst_data", inst, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (redir) begin
            model_fpc = {tgt[31:2], 2'b00};
            exp_pc    = {tgt[31:2], 2'b00};
        end

        prev_redir   = redir;
        prev_req     = mem_req;
        prev_gnt     = mem_gnt;
        prev_valid   = inst_valid;
        prev_ready   = inst_ready;
        prev_addr    = mem_addr;
        prev_inst    = inst;
        prev_inst_pc = inst_pc;
    endtask

    // Bound every wait: a found condition leaves this at 1.
    task automatic wait_wait_state(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (out_busy && out_delay > 0) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int first_valid;
        rst = 1'b1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
        clear_model();
        coincide_mode = 1'b0; coincide_hit = 1'b0;
        gnt_pct = 100; ready_pct = 100; redir_pct = 0; lat_max = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0000_0000);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0000_0000);
        check("rst_inst_pc", inst_pc, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;

        // 1-cycle memory, always ready: latency and throughput
        pops = 0; issues = 0; first_valid = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (inst_valid && first_valid == 0) first_valid = i;
        end
        check("first_valid_latency", 32'(first_valid), 32'd3);
        check("throughput_pops", 32'(pops), 32'd5);
        check("throughput_issues", 32'(issues), 32'd6);

        // backpressure: buffer fills, requests stop, then in-order drain
        ready_pct = 0;
        repeat (10) step();
        check("full_req_low", 32'(mem_req), 32'd0);
        check("full_valid", 32'(inst_valid), 32'd1);
        gnt_pct = 0; ready_pct = 100; pops = 0;
        repeat (6) step();
        check("drain_count", 32'(pops), 32'd2);

        // redirect while a read is outstanding
        gnt_pct = 100; lat_max = 3;
        wait_wait_state("find_wait_a");
        force_redir = 1'b1; force_tgt = 32'h0000_0102;
        step();
        issues = 0; valid_cnt = 0;
        for (int i = 0; i < 12 && issues == 0; i++) begin
            step();
            if (inst_valid) valid_cnt++;
        end
        check("redir_issue_seen", 32'(issues), 32'd1);
        check("redir_issue_addr", last_issue_addr, 32'h0000_0100);
        check("redir_fifo_empty", 32'(valid_cnt), 32'd0);

        // grant held low: request and address stable, redirect retargets
        gnt_pct = 0;
        repeat (5) step();
        check("hold_req_up", 32'(mem_req), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                force_redir = 1'b1;
                force_tgt   = 32'h0000_0200;
            end
            step();
            if (i == 3) begin
                check("retarget_req", 32'(mem_req), 32'd1);
                check("retarget_addr", mem_addr, 32'h0000_0200);
            end
        end

        // redirect in the same cycle as a push and a pop
        gnt_pct = 100; lat_max = 1; ready_pct = 0;
        coincide_mode = 1'b1; coincide_hit = 1'b0; force_tgt = 32'h0000_0300;
        for (int i = 0; i < 20 && !coincide_hit; i++) step();
        check("coincide_hit", 32'(coincide_hit), 32'd1);
        coincide_mode = 1'b0; ready_pct = 100;
        step();
        check("coincide_flush", 32'(inst_valid), 32'd0);

        // address wrap at the top of memory
        force_redir = 1'b1; force_tgt = 32'hFFFF_FFFC;
        step();
        issues = 0;
        for (int i = 0; i < 12 && issues < 1; i++) step();
        check("wrap_first_addr", last_issue_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 12 && issues < 2; i++) step();
        check("wrap_next_addr", last_issue_addr, 32'h0000_0000);

        // asynchronous reset mid-read, late response must be ignored
        lat_max = 3;
        wait_wait_state("find_wait_b");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mem_req", 32'(mem_req), 32'd0);
        check("arst_mem_addr", mem_addr, 32'h0000_0000);
        check("arst_inst_valid", 32'(inst_valid), 32'd0);
        check("arst_inst", inst, 32'h0000_0000);
        check("arst_inst_pc", inst_pc, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        mem_gnt = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
        lat_max = 1; pops = 0;
        repeat (10) step();
        check("post_reset_progress", 32'(pops > 0), 32'd1);

        // randomized traffic with redirects
        gnt_pct = 70; ready_pct = 60; redir_pct = 4; lat_max = 3; pops = 0;
        repeat (3000) step();
        redir_pct = 0; gnt_pct = 100; ready_pct = 100;
        repeat (20) step();
        check("random_progress", 32'(pops >= 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
